timerio: RTL and testbench
==========================

// Module: timerio
// PURPOSE
//  16-bit programmable down-counter timer peripheral on the cpu68 bus, decoded at $E620 (DS1), AD[3:0] used.
//  Provides a periodic or one-shot tick, a compare match and a square-wave output.
//  irq is OR-ed into the system IRQ alongside vpu/simpleio/uartio; tout is free for LEDs/ext pins.
// PARAMETERS
//  RELOAD_RST  16'hFFFF  reset value of RLD register
//  PRESC_RST   8'd0      reset value of PRESC register
// PORTS
//  clk   in   1  sys_clk; all state on rising edge
//  rst   in   1  synchronous, active-high reset
//  irq   out  1  interrupt request, level, active-high
//  AD    in   4  register select
//  DI    in   8  write data from CPU
//  DO    out  8  read data to CPU (combinational from registers/shadow)
//  rw    in   1  1=read, 0=write
//  cs    in   1  access strobe (decode && vma); one access = one clk with cs=1
//  tout  out  1  toggles on every underflow
// BEHAVIOUR
//  Reg map: 0 CTRL[3:0]={CMPIE,OVFIE,AUTO,EN} rw; 1 STAT[1:0]={CMPF,OVFF} r, write-1-to-clear;
//   2 PRESC rw; 3 CNT_H; 4 CNT_L; 5 RLD_H; 6 RLD_L; 7 CMP_H; 8 CMP_L; 9-15 read 8'hFF, writes ignored.
//   Unused CTRL/STAT bits read 0.
//  Reset: CTRL=0, STAT=0, PRESC=PRESC_RST, CNT=16'hFFFF, RLD=RELOAD_RST, CMP=16'h0000,
//   pcnt=0, hbuf=0, lshadow=0, tout=0, irq=0.
//  16-bit write: write to *_H stores DI in shared hbuf only; write to *_L commits {hbuf,DI} atomically.
//   CNT_L write also clears pcnt.
//  16-bit read: read of CNT_H returns CNT[15:8] and latches CNT[7:0] into lshadow on that edge;
//   CNT_L read returns lshadow. RLD/CMP read directly (no latch).
//  Prescaler: when EN=1, pcnt increments each clk; when pcnt==PRESC: tick=1, pcnt<=0.
//   PRESC=0 => tick every clk. EN=0 holds pcnt and CNT.
//  On tick:
//   - CNT!=0: CNT<=CNT-1.
//   - CNT==0 (underflow): OVFF<=1, tout<=~tout.
//     AUTO=1: CNT<=RLD. AUTO=0: CNT<=16'hFFFF and EN<=0 (one-shot stop).
//  Compare: CMPF<=1 on the edge where the newly loaded CNT value equals CMP (tick-caused loads only, not CPU writes).
//  irq = (OVFF & OVFIE) | (CMPF & CMPIE); driven from registered state, no extra latency.
//  Priority/simultaneity:
//   - CPU write to CNT_L in same cycle as tick: CPU value wins, no decrement, no flags.
//   - STAT clear and hardware set of same flag in same cycle: set wins.
//   - CTRL write with EN=0 in same cycle as tick: write wins, tick ignored.
//   - Writing CTRL EN 0->1 does not reset pcnt or CNT.
//  Reads have no side effects except CNT_H latch; cs=0 cycles have no side effects.
//  rst mid-count: all state returns to reset values next edge; tout returns to 0.
// TESTING
//  Reset, read regs 0..8 -> 00,00,PRESC_RST,FF,FF,RLD_H,RLD_L,00,00; reg 12 -> FF; irq=0, tout=0.
//  RLD=0x0003, CNT=0x0003, PRESC=0, CTRL=0x07 -> OVFF set, tout toggles and irq asserts
//   every 4 clk; CNT reloads 3.
//  PRESC=2, CNT=0x0001, CTRL=0x01 (one-shot) -> underflow after 6 clk; CTRL reads 0x00,
//   CNT=0xFFFF, count frozen.
//  CMP=0x0005, CNT=0x0008, CTRL=0x09 -> CMPF and irq after 3 ticks; writing STAT=0x02 clears it,
//   irq drops next clk.
//  CNT=0x12FF free-running; read CNT_H (0x12), run 10 clk, read CNT_L -> returns latched 0xFF,
//   not live value.
//  Write STAT=0x01 on the same edge OVFF is set -> OVFF reads 1; write CNT_L on a tick edge ->
//   CNT equals written value.

Source files
------------

// File: rtl/timerio.sv
// timerio: 16-bit programmable down-counter timer on the cpu68 bus.
// Prescaled tick, auto-reload or one-shot, compare match flag, square-wave
// output toggling on every underflow, and a level interrupt request.
// 16-bit registers are written through a shared high-byte buffer (hbuf) and
// the counter is read coherently through a low-byte shadow latched on CNT_H read.
module timerio #(
  parameter logic [15:0] RELOAD_RST = 16'hFFFF,
  parameter logic [7:0]  PRESC_RST  = 8'd0
) (
  input  logic       clk,
  input  logic       rst,
  output logic       irq,
  input  logic [3:0] AD,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  input  logic       rw,
  input  logic       cs,
  output logic       tout
);

  // CTRL bit positions
  localparam int CTRL_EN    = 0;
  localparam int CTRL_AUTO  = 1;
  localparam int CTRL_OVFIE = 2;
  localparam int CTRL_CMPIE = 3;

  logic [3:0]  r_ctrl;
  logic [1:0]  r_stat;     // {CMPF, OVFF}
  logic [7:0]  r_presc;
  logic [7:0]  r_pcnt;
  logic [15:0] r_cnt;
  logic [15:0] r_rld;
  logic [15:0] r_cmp;
  logic [7:0]  r_hbuf;
  logic [7:0]  r_lshadow;
  logic        r_tout;

  logic        w_wr;
  logic        w_rd;
  logic        w_wr_ctrl;
  logic        w_wr_cnt_l;
  logic        w_run;
  logic        w_pmatch;
  logic        w_tick;
  logic        w_unf;
  logic [15:0] w_cnt_tick;
  logic        w_cmp_hit;

  assign w_wr       = cs & ~rw;
  assign w_rd       = cs & rw;
  assign w_wr_ctrl  = w_wr & (AD == 4'd0);
  assign w_wr_cnt_l = w_wr & (AD == 4'd4);

  // A CTRL write that clears EN takes effect immediately: the prescaler and
  // counter do not advance on that edge.
  assign w_run    = r_ctrl[CTRL_EN] & ~(w_wr_ctrl & ~DI[CTRL_EN]);
  assign w_pmatch = (r_pcnt == r_presc);
  // A CPU load of CNT beats a coincident tick.
  assign w_tick   = w_run & w_pmatch & ~w_wr_cnt_l;
  assign w_unf    = w_tick & (r_cnt == 16'd0);

  // Value the counter takes on a tick; also what the compare looks at.
  assign w_cnt_tick = (r_cnt != 16'd0) ? (r_cnt - 16'd1) :
                      (r_ctrl[CTRL_AUTO] ? r_rld : 16'hFFFF);
  assign w_cmp_hit  = w_tick & (w_cnt_tick == r_cmp);

  // Control register; one-shot underflow drops EN unless the CPU writes CTRL.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl <= 4'd0;
    end else if (w_wr_ctrl) begin
      r_ctrl <= DI[3:0];
    end else if (w_unf & ~r_ctrl[CTRL_AUTO]) begin
      r_ctrl[CTRL_EN] <= 1'b0;
    end
  end

  // Status flags: write-1-to-clear, hardware set wins over a same-edge clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat <= 2'b00;
    end else begin
      r_stat <= (r_stat & ~((w_wr && AD == 4'd1) ? DI[1:0] : 2'b00))
              | {w_cmp_hit, w_unf};
    end
  end

  // Prescaler counter: wraps at PRESC, cleared by a CNT_L write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcnt <= 8'd0;
    end else if (w_wr_cnt_l) begin
      r_pcnt <= 8'd0;
    end else if (w_run) begin
      r_pcnt <= w_pmatch ? 8'd0 : (r_pcnt + 8'd1);
    end
  end

  // Main counter: CPU load has priority over the tick-driven update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 16'hFFFF;
    end else if (w_wr_cnt_l) begin
      r_cnt <= {r_hbuf, DI};
    end else if (w_tick) begin
      r_cnt <= w_cnt_tick;
    end
  end

  // Plain CPU-written registers and the shared high-byte buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= PRESC_RST;
      r_rld   <= RELOAD_RST;
      r_cmp   <= 16'h0000;
      r_hbuf  <= 8'd0;
    end else if (w_wr) begin
      case (AD)
        4'd2:                r_presc <= DI;
        4'd3, 4'd5, 4'd7:    r_hbuf  <= DI;
        4'd6:                r_rld   <= {r_hbuf, DI};
        4'd8:                r_cmp   <= {r_hbuf, DI};
        default: ;
      endcase
    end
  end

  // Low-byte shadow captured when the CPU reads CNT_H.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lshadow <= 8'd0;
    end else if (w_rd && AD == 4'd3) begin
      r_lshadow <= r_cnt[7:0];
    end
  end

  // Square wave: flips on each underflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tout <= 1'b0;
    end else if (w_unf) begin
      r_tout <= ~r_tout;
    end
  end

  // Read mux from registered state.
  always_comb begin
    DO = 8'hFF;
    case (AD)
      4'd0:    DO = {4'd0, r_ctrl};
      4'd1:    DO = {6'd0, r_stat};
      4'd2:    DO = r_presc;
      4'd3:    DO = r_cnt[15:8];
      4'd4:    DO = r_lshadow;
      4'd5:    DO = r_rld[15:8];
      4'd6:    DO = r_rld[7:0];
      4'd7:    DO = r_cmp[15:8];
      4'd8:    DO = r_cmp[7:0];
      default: DO = 8'hFF;
    endcase
  end

  assign irq  = (r_stat[0] & r_ctrl[CTRL_OVFIE]) | (r_stat[1] & r_ctrl[CTRL_CMPIE]);
  assign tout = r_tout;

endmodule

// File: tb/tb_timerio.sv
// Self-checking bench for timerio: directed scenarios followed by random bus
// traffic, all compared against a cycle-level behavioural model of the timer.
module tb_timerio;

    localparam logic [15:0] RLD_RST = 16'hFFFF;
    localparam logic [7:0]  PS_RST  = 8'd0;

    logic       clk;
    logic       rst;
    logic       irq;
    logic [3:0] AD;
    logic [7:0] DI;
    logic [7:0] DO;
    logic       rw;
    logic       cs;
    logic       tout;

    int n_checks = 0;
    int n_fail   = 0;
    bit verbose  = 1'b1;
    logic [7:0] last_do;

    // behavioural model state
    logic [3:0]  m_ctrl;
    logic [1:0]  m_stat;
    logic [7:0]  m_presc;
    logic [7:0]  m_pcnt;
    logic [15:0] m_cnt;
    logic [15:0] m_rld;
    logic [15:0] m_cmp;
    logic [7:0]  m_hbuf;
    logic [7:0]  m_lsh;
    logic        m_tout;

    timerio #(.RELOAD_RST(RLD_RST), .PRESC_RST(PS_RST)) dut (
        .clk (clk),
        .rst (rst),
        .irq (irq),
        .AD  (AD),
        .DI  (DI),
        .DO  (DO),
        .rw  (rw),
        .cs  (cs),
        .tout(tout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_read(input logic [3:0] a);
        case (a)
            4'd0:    return {4'd0, m_ctrl};
            4'd1:    return {6'd0, m_stat};
            4'd2:    return m_presc;
            4'd3:    return m_cnt[15:8];
            4'd4:    return m_lsh;
            4'd5:    return m_rld[15:8];
            4'd6:    return m_rld[7:0];
            4'd7:    return m_cmp[15:8];
            4'd8:    return m_cmp[7:0];
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic model_irq();
        return (m_stat[0] & m_ctrl[2]) | (m_stat[1] & m_ctrl[3]);
    endfunction

    // One clock edge of the timer described by its rules, from the old state.
    task automatic model_step(input bit c, input bit r, input logic [3:0] a,
                              input logic [7:0] d, input bit rs);
        bit          wr, rd, stop_wr, load_wr, running, tick, under, cmpset;
        logic [15:0] newcnt;
        if (rs) begin
            m_ctrl = 4'd0;  m_stat = 2'd0; m_presc = PS_RST; m_pcnt = 8'd0;
            m_cnt = 16'hFFFF; m_rld = RLD_RST; m_cmp = 16'h0000;
            m_hbuf = 8'd0; m_lsh = 8'd0; m_tout = 1'b0;
            return;
        end
        wr      = c && !r;
        rd      = c && r;
        stop_wr = wr && a == 4'd0 && d[0] == 1'b0;
        load_wr = wr && a == 4'd4;
        running = m_ctrl[0] && !stop_wr;
        tick    = running && (m_pcnt == m_presc) && !load_wr;
        under   = tick && (m_cnt == 16'd0);
        newcnt  = m_cnt;
        cmpset  = 1'b0;
        if (tick) begin
            if (m_cnt == 16'd0) newcnt = m_ctrl[1] ? m_rld : 16'hFFFF;
            else                newcnt = m_cnt - 16'd1;
            cmpset = (newcnt == m_cmp);
        end
        if (rd && a == 4'd3) m_lsh = m_cnt[7:0];
        if (load_wr)      m_pcnt = 8'd0;
        else if (running) m_pcnt = (m_pcnt == m_presc) ? 8'd0 : m_pcnt + 8'd1;
        if (load_wr) m_cnt = {m_hbuf, d};
        else         m_cnt = newcnt;
        if (wr && a == 4'd1) m_stat = m_stat & ~d[1:0];
        if (under)  m_stat[0] = 1'b1;
        if (cmpset) m_stat[1] = 1'b1;
        if (under) m_tout = ~m_tout;
        if (wr && a == 4'd0)         m_ctrl = d[3:0];
        else if (under && !m_ctrl[1]) m_ctrl[0] = 1'b0;
        if (wr) begin
            case (a)
                4'd2:             m_presc = d;
                4'd6:             m_rld = {m_hbuf, d};
                4'd8:             m_cmp = {m_hbuf, d};
                default: ;
            endcase
            if (a == 4'd3 || a == 4'd5 || a == 4'd7) m_hbuf = d;
        end
    endtask

    // One bus clock: drive, check read data before the edge, step model, check outputs.
    task automatic do_cycle(input bit c, input bit r, input logic [3:0] a,
                            input logic [7:0] d, input bit rs);
        @(negedge clk);
        cs = c; rw = r; AD = a; DI = d; rst = rs;
        #1;
        last_do = DO;
        if (c && r && !rs) check_eq($sformatf("rd%0d", a), {8'd0, DO}, {8'd0, model_read(a)});
        if (verbose && c) $display("%s ad=%0d di=%h do=%h rst=%0d", r ? "RD" : "WR", a, d, DO, rs);
        @(posedge clk);
        model_step(c, r, a, d, rs);
        #1;
        check_eq("irq",  {15'd0, irq},  {15'd0, model_irq()});
        check_eq("tout", {15'd0, tout}, {15'd0, m_tout});
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [7:0] d);
        do_cycle(1'b1, 1'b0, a, d, 1'b0);
    endtask

    task automatic rd_reg(input logic [3:0] a);
        do_cycle(1'b1, 1'b1, a, 8'h00, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) do_cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    endtask

    logic [7:0] rst_exp [0:8];

    initial begin
        rst = 1'b1; cs = 1'b0; rw = 1'b1; AD = 4'd0; DI = 8'd0;
        rst_exp[0] = 8'h00; rst_exp[1] = 8'h00; rst_exp[2] = PS_RST;
        rst_exp[3] = 8'hFF; rst_exp[4] = 8'hFF; rst_exp[5] = RLD_RST[15:8];
        rst_exp[6] = RLD_RST[7:0]; rst_exp[7] = 8'h00; rst_exp[8] = 8'h00;
        do_cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
        do_cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);

        // reset contents
        for (int i = 0; i < 9; i++) begin
            rd_reg(4'(i));
            check_eq($sformatf("rst_reg%0d", i), {8'd0, last_do}, {8'd0, rst_exp[i]});
        end
        rd_reg(4'd12);
        check_eq("rst_reg12", {8'd0, last_do}, 16'h00FF);
        check_eq("rst_irq",  {15'd0, irq},  16'd0);
        check_eq("rst_tout", {15'd0, tout}, 16'd0);

        // auto-reload every 4 clocks
        wr_reg(4'd5, 8'h00); wr_reg(4'd6, 8'h03);
        wr_reg(4'd3, 8'h00); wr_reg(4'd4, 8'h03);
        wr_reg(4'd2, 8'h00); wr_reg(4'd0, 8'h07);
        idle(4);
        check_eq("auto_irq",  {15'd0, irq},  16'd1);
        check_eq("auto_tout", {15'd0, tout}, 16'd1);
        idle(4);
        check_eq("auto_tout2", {15'd0, tout}, 16'd0);
        wr_reg(4'd0, 8'h00); wr_reg(4'd1, 8'h03);

        // one-shot with prescaler 2
        wr_reg(4'd2, 8'h02); wr_reg(4'd3, 8'h00); wr_reg(4'd4, 8'h01);
        wr_reg(4'd0, 8'h01);
        idle(6);
        rd_reg(4'd0);
        check_eq("oneshot_ctrl", {8'd0, last_do}, 16'h0000);
        rd_reg(4'd3);
        check_eq("oneshot_cnth", {8'd0, last_do}, 16'h00FF);
        idle(5);
        rd_reg(4'd4);
        check_eq("oneshot_frozen", {8'd0, last_do}, 16'h00FF);

        // compare match
        wr_reg(4'd1, 8'h03); wr_reg(4'd2, 8'h00);
        wr_reg(4'd7, 8'h00); wr_reg(4'd8, 8'h05);
        wr_reg(4'd3, 8'h00); wr_reg(4'd4, 8'h08);
        wr_reg(4'd0, 8'h09);
        idle(3);
        check_eq("cmp_irq", {15'd0, irq}, 16'd1);
        wr_reg(4'd0, 8'h08);
        wr_reg(4'd1, 8'h02);
        check_eq("cmp_clr_irq", {15'd0, irq}, 16'd0);

        // coherent 16-bit counter read
        wr_reg(4'd0, 8'h01);
        wr_reg(4'd3, 8'h12); wr_reg(4'd4, 8'hFF);
        rd_reg(4'd3);
        check_eq("latch_h", {8'd0, last_do}, 16'h0012);
        idle(10);
        rd_reg(4'd4);
        check_eq("latch_l", {8'd0, last_do}, 16'h00FF);

        // set-wins clear, CPU load on a tick edge
        wr_reg(4'd0, 8'h00); wr_reg(4'd1, 8'h03);
        wr_reg(4'd3, 8'h00); wr_reg(4'd4, 8'h02);
        wr_reg(4'd0, 8'h03);
        idle(2);
        wr_reg(4'd1, 8'h01);
        rd_reg(4'd1);
        check_eq("set_wins", {15'd0, last_do[0]}, 16'd1);
        wr_reg(4'd3, 8'h40); wr_reg(4'd4, 8'h00);
        rd_reg(4'd3);
        check_eq("cpu_wins_h", {8'd0, last_do}, 16'h0040);
        rd_reg(4'd4);
        check_eq("cpu_wins_l", {8'd0, last_do}, 16'h0000);
        wr_reg(4'd0, 8'h00);

        // random traffic with occasional reset
        verbose = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            bit         c, r, rs;
            logic [3:0] a;
            logic [7:0] d;
            rs = ($urandom % 300) == 0;
            c  = ($urandom % 10) < 6;
            r  = ($urandom % 2) == 1;
            a  = (($urandom % 8) == 0) ? 4'($urandom) : 4'($urandom_range(0, 8));
            d  = 8'($urandom);
            if (a == 4'd2) d = 8'($urandom_range(0, 3));
            if ((a == 4'd3 || a == 4'd5 || a == 4'd7) && ($urandom % 4) != 0) d = 8'h00;
            if (a == 4'd4 || a == 4'd6 || a == 4'd8) d = 8'($urandom_range(0, 31));
            if (a == 4'd0 && ($urandom % 3) != 0) d[0] = 1'b1;
            do_cycle(c, r, a, d, rs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
